// File: rtl/program_seq_pkg.sv
// Shared definitions for the program sequencer: op and state encodings,
// default widths and the field layout of an instruction word.
// Instruction word layout, MSB to LSB: op (2 bits), target (ADDR_W), ctrl (CTRL_W).
package program_seq_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_CTRL_W = 4;
    localparam int OP_W       = 2;

    typedef enum logic [1:0] {
        OP_EXEC = 2'b00,
        OP_JC   = 2'b01,
        OP_JMP  = 2'b10,
        OP_HALT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    // Total instruction width for a given address/control width.
    function automatic int instrWidth(input int addrW, input int ctrlW);
        return OP_W + addrW + ctrlW;
    endfunction

    // Lowest bit of the ctrl field.
    function automatic int ctrlLsb();
        return 0;
    endfunction

    // Lowest bit of the jump-target field.
    function automatic int targetLsb(input int ctrlW);
        return ctrlW;
    endfunction

    // Lowest bit of the op field.
    function automatic int opLsb(input int addrW, input int ctrlW);
        return addrW + ctrlW;
    endfunction

endpackage

// File: rtl/program_sequencer_instr_store.sv
// Writable instruction store: 2**ADDR_W words, one synchronous write port
// and one combinational read port. Deliberately has no reset so a loaded
// program survives a sequencer reset.
module instr_store #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/program_sequencer.sv
// Instruction-fetch and sequencing stage feeding the datapath control word.
// Runs one instruction per cycle from a writable store, with EXEC, JC, JMP
// and HALT ops. Optional build macro SINGLE_STEP_EN adds a 'step' input that
// gates advancement (and ctrl_out) while running.
module program_sequencer
    import program_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
`ifdef SINGLE_STEP_EN
    input  logic                       step,
`endif
    input  logic                       prog_valid,
    output logic                       prog_ready,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [2+ADDR_W+CTRL_W-1:0] prog_data,
    input  logic                       carry_in,
    output logic [CTRL_W-1:0]          ctrl_out,
    output logic [ADDR_W-1:0]          pc_out,
    output logic                       running,
    output logic                       halted
);

    localparam int IW       = instrWidth(ADDR_W, CTRL_W);
    localparam int OP_LSB   = opLsb(ADDR_W, CTRL_W);
    localparam int TGT_LSB  = targetLsb(CTRL_W);
    localparam int CTRL_LSB = ctrlLsb();

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IW-1:0]     instr;
    op_e               op;
    logic [ADDR_W-1:0] target;
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] pcNext;
    logic              advance;
    logic              wrEn;

    // Writes are only accepted while not running; nothing is queued.
    assign prog_ready = (state_q != ST_RUN);
    assign wrEn       = prog_valid && prog_ready;

    instr_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (IW)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (wrEn),
        .wr_addr_i (prog_addr),
        .wr_data_i (prog_data),
        .rd_addr_i (pc_q),
        .rd_data_o (instr)
    );

    assign op     = op_e'(instr[OP_LSB +: OP_W]);
    assign target = instr[TGT_LSB +: ADDR_W];
    assign ctrl   = instr[CTRL_LSB +: CTRL_W];
    assign pcNext = pc_q + ADDR_W'(1);

`ifdef SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // Next state, next pc and the datapath control word; stop beats start beats op.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ctrl_out = '0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (op == OP_EXEC && advance) begin
                    ctrl_out = ctrl;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end else if (advance) begin
                    unique case (op)
                        OP_EXEC: pc_d = pcNext;
                        OP_JC:   pc_d = carry_in ? target : pcNext;
                        OP_JMP:  pc_d = target;
                        OP_HALT: state_d = ST_HALT;
                        default: pc_d = pc_q;
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // State and program counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_out  = pc_q;
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALT);

endmodule
